// File: rtl/mul_acc_ctrl.sv
// Multiply-accumulate sequencer: feeds an external 8x8 multiplier, folds the
// 16-bit product into an accumulator and writes the result out as two bytes.
module mul_acc_ctrl #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        acc_en,
  input  logic        clr_acc,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic [2:0]  dest,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        busy,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic        done,
  output logic        ovf,
  output logic        zero
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    ACC  = 3'd2,
    WRLO = 3'd3,
    WRHI = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  dest_q;
  logic        acc_en_q;
  logic [15:0] prod_q;
  logic [15:0] acc;
  logic [15:0] acc_nxt;
  logic [16:0] sum;
  logic        carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    state_nxt = ACC;
      ACC:     state_nxt = WRLO;
      WRLO:    state_nxt = WRHI;
      WRHI:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state alone, so an async reset clears them at once.
  always_comb begin
    busy     = 1'b0;
    mul_a    = 8'h00;
    mul_b    = 8'h00;
    rf_we    = 1'b0;
    rf_waddr = 3'd0;
    rf_wdata = 8'h00;
    done     = 1'b0;
    if (state != IDLE) begin
      busy  = 1'b1;
      mul_a = a_q;
      mul_b = b_q;
    end
    case (state)
      WRLO: begin
        rf_we    = 1'b1;
        rf_waddr = dest_q;
        rf_wdata = acc[7:0];
      end
      WRHI: begin
        rf_we    = 1'b1;
        rf_waddr = dest_q + 3'd1;
        rf_wdata = acc[15:8];
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sum   = {1'b0, acc} + {1'b0, prod_q};
    carry = acc_en_q & sum[16];
    if (!acc_en_q) begin
      acc_nxt = prod_q;
    end else if (sum[16] && SATURATE) begin
      acc_nxt = 16'hFFFF;
    end else begin
      acc_nxt = sum[15:0];
    end
  end

  // A clear and a start in the same IDLE cycle both land before ACC reads acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      dest_q   <= 3'd0;
      acc_en_q <= 1'b0;
      prod_q   <= 16'h0000;
      acc      <= 16'h0000;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_acc) begin
            acc <= 16'h0000;
          end
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            dest_q   <= dest;
            acc_en_q <= acc_en;
          end
        end
        CALC: prod_q <= mul_p;
        ACC: begin
          acc  <= acc_nxt;
          ovf  <= carry;
          zero <= (acc_nxt == 16'h0000);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_acc_ctrl.sv
// Scoreboard bench for mul_acc_ctrl: a saturating and a wrapping instance share
// stimulus; an arithmetic model predicts each two-byte write and its timing.
module tb_mul_acc_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] lo_addr;
    logic [7:0] lo_data;
    logic [2:0] hi_addr;
    logic [7:0] hi_data;
    logic       ovf;
    logic       zero;
    int         done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        acc_en = 1'b0;
  logic        clr_acc = 1'b0;
  logic [7:0]  op_a = 8'h00;
  logic [7:0]  op_b = 8'h00;
  logic [2:0]  dest = 3'd0;

  logic [7:0]  mul_a    [2];
  logic [7:0]  mul_b    [2];
  logic [15:0] mul_p    [2];
  logic        busy     [2];
  logic        rf_we    [2];
  logic [2:0]  rf_waddr [2];
  logic [7:0]  rf_wdata [2];
  logic        done     [2];
  logic        ovf      [2];
  logic        zero     [2];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   next_free = 0;
  int   last_start = -100;
  int   acc_m [2];
  exp_t q0 [$];
  exp_t q1 [$];

  mul_acc_ctrl #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_en(acc_en), .clr_acc(clr_acc),
    .op_a(op_a), .op_b(op_b), .dest(dest),
    .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p[0]),
    .busy(busy[0]), .rf_we(rf_we[0]), .rf_waddr(rf_waddr[0]), .rf_wdata(rf_wdata[0]),
    .done(done[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  mul_acc_ctrl #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_en(acc_en), .clr_acc(clr_acc),
    .op_a(op_a), .op_b(op_b), .dest(dest),
    .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p[1]),
    .busy(busy[1]), .rf_we(rf_we[1]), .rf_waddr(rf_waddr[1]), .rf_wdata(rf_wdata[1]),
    .done(done[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  // External combinational multiplier seen by each instance
  assign mul_p[0] = 16'(mul_a[0]) * 16'(mul_b[0]);
  assign mul_p[1] = 16'(mul_a[1]) * 16'(mul_b[1]);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, actual, required);
    end
  endtask

  function automatic exp_t frontOf(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int qSize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void popFront(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  task automatic modelReset();
    acc_m[0]   = 0;
    acc_m[1]   = 0;
    next_free  = 0;
    last_start = -100;
    q0.delete();
    q1.delete();
  endtask

  task automatic checkReset(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_outs%0d", tag, i),
                  {busy[i], rf_we[i], done[i], rf_waddr[i], rf_wdata[i],
                   mul_a[i], mul_b[i], ovf[i], zero[i]}, 64'd0);
    end
  endtask

  // Drive one cycle of inputs; the model decides acceptance from its own timeline
  task automatic applyStimulus(input bit st, input bit ae, input bit clr,
                               input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
    int   prod;
    int   sum;
    exp_t e;
    @(posedge clk);
    #2;
    start   = st;
    acc_en  = ae;
    clr_acc = clr;
    op_a    = a;
    op_b    = b;
    dest    = d;
    if (cyc >= next_free) begin
      if (clr) begin
        acc_m[0] = 0;
        acc_m[1] = 0;
      end
      if (st) begin
        last_start = cyc;
        next_free  = cyc + 5;
        prod = int'(a) * int'(b);
        for (int i = 0; i < 2; i++) begin
          e.ovf = 1'b0;
          if (ae) begin
            sum = acc_m[i] + prod;
            if (sum > 65535) begin
              e.ovf = 1'b1;
              acc_m[i] = (i == 0) ? 65535 : sum - 65536;
            end else begin
              acc_m[i] = sum;
            end
          end else begin
            acc_m[i] = prod;
          end
          e.a        = a;
          e.b        = b;
          e.lo_addr  = d;
          e.lo_data  = 8'(acc_m[i] % 256);
          e.hi_addr  = 3'((int'(d) + 1) % 8);
          e.hi_data  = 8'(acc_m[i] / 256);
          e.zero     = (acc_m[i] == 0);
          e.done_cyc = cyc + 4;
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'($urandom), 1'b0, 8'($urandom), 8'($urandom), 3'($urandom));
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    clr_acc = 1'b0;
    #1;
    checkReset("midreset");
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every register-file write against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bit   busy_exp;
        exp_t e;
        busy_exp = (cyc >= last_start + 1) && (cyc <= last_start + 4);
        checkOutput($sformatf("busy%0d", i), 64'(busy[i]), 64'(busy_exp));
        checkOutput($sformatf("done_without_we%0d", i), 64'(done[i] & ~rf_we[i]), 64'd0);
        if (!busy_exp) begin
          checkOutput($sformatf("idle_outs%0d", i),
                      {rf_we[i], done[i], rf_waddr[i], rf_wdata[i], mul_a[i], mul_b[i]}, 64'd0);
        end
        if (qSize(i) > 0) begin
          e = frontOf(i);
          if (busy_exp) begin
            checkOutput($sformatf("mul_ops%0d", i), {mul_a[i], mul_b[i]}, {e.a, e.b});
          end
          if (rf_we[i]) begin
            if (done[i]) begin
              checkOutput($sformatf("done_cycle%0d", i), 64'(cyc), 64'(e.done_cyc));
              checkOutput($sformatf("hi_write%0d", i), {rf_waddr[i], rf_wdata[i]}, {e.hi_addr, e.hi_data});
              checkOutput($sformatf("flags%0d", i), {ovf[i], zero[i]}, {e.ovf, e.zero});
              popFront(i);
            end else begin
              checkOutput($sformatf("lo_cycle%0d", i), 64'(cyc), 64'(e.done_cyc - 1));
              checkOutput($sformatf("lo_write%0d", i), {rf_waddr[i], rf_wdata[i]}, {e.lo_addr, e.lo_data});
            end
          end else if (cyc >= e.done_cyc) begin
            checkOutput($sformatf("missing_done%0d", i), 64'(done[i]), 64'd1);
            popFront(i);
          end
        end else if (rf_we[i]) begin
          checkOutput($sformatf("unexpected_write%0d", i), 64'(rf_we[i]), 64'd0);
        end
      end
    end
  end

  initial begin
    modelReset();
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    $display("[TB] directed: load, saturation, wrap, clear");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h0C, 8'h0A, 3'd2);
    idle(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 3'd4);
    idle(4);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 3'd4);
    idle(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 3'd7);
    idle(4);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h55, 3'd1);
    idle(5);

    $display("[TB] directed: start during ACC, reset during WRLO");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h33, 8'h44, 3'd5);
    idle(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 8'h88, 3'd6);
    idle(6);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h21, 8'h43, 3'd3);
    idle(2);
    doReset();
    idle(8);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 9) < 4), 1'($urandom), ($urandom_range(0, 9) == 0),
                    8'($urandom), 8'($urandom), 3'($urandom));
    end
    idle(8);
    checkOutput("queue_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
